// File: rtl/start_trigger.sv
// Start-pulse generator: synchronises and debounces a raw trigger and issues one-cycle start pulses.
// It holds one request pending while downstream is busy. Define START_TRIG_CNT_EN to add the o_trig_cnt fire counter.
module start_trigger #(
    parameter int DEB_VAL      = 4,
    parameter int DEB_VAL_SIZE = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ce,
    input  logic       i_btn,
    input  logic       i_busy,
    output logic       o_start,
    output logic       o_pending,
`ifdef START_TRIG_CNT_EN
    output logic [7:0] o_trig_cnt,
`endif
    output logic       o_btn_db
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FIRE,
        WAIT_ACK
    } state_t;

    localparam logic [DEB_VAL_SIZE-1:0] DEB_LAST = DEB_VAL_SIZE'(DEB_VAL - 1);

    logic                    sync_q1;
    logic                    btn_s;
    logic [DEB_VAL_SIZE-1:0] deb_cnt;
    logic                    btn_db_q;
    logic                    rise;
    logic                    req;
    logic                    pend;
    logic                    next_pend;
    logic [1:0]              tmo;
    logic [1:0]              next_tmo;
    state_t                  state;
    state_t                  next_state;

    // Two-flop synchroniser runs every cycle; only the debounce count is ce-gated.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q1 <= 1'b0;
            btn_s   <= 1'b0;
        end else begin
            sync_q1 <= i_btn;
            btn_s   <= sync_q1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            deb_cnt  <= '0;
            o_btn_db <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= o_btn_db;
            if (btn_s == o_btn_db) begin
                deb_cnt <= '0;
            end else if (i_ce) begin
                if (deb_cnt == DEB_LAST) begin
                    o_btn_db <= ~o_btn_db;
                    deb_cnt  <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end
        end
    end

    assign rise = o_btn_db & ~btn_db_q;
    assign req  = rise | pend;

    // A rise seen while a start is already in flight is parked in the single-depth pending flag.
    always_comb begin
        next_state = state;
        next_pend  = pend;
        next_tmo   = 2'd0;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = i_busy ? ARMED : FIRE;
                end
            end
            ARMED: begin
                if (!i_busy) begin
                    next_state = FIRE;
                end
            end
            FIRE: begin
                next_state = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (i_busy || tmo == 2'd3) begin
                    next_state = IDLE;
                end else begin
                    next_tmo = tmo + 2'd1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (rise && state != IDLE) begin
            next_pend = 1'b1;
        end
        if (next_state == FIRE) begin
            next_pend = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            pend      <= 1'b0;
            tmo       <= 2'd0;
            o_start   <= 1'b0;
            o_pending <= 1'b0;
        end else begin
            state     <= next_state;
            pend      <= next_pend;
            tmo       <= next_tmo;
            o_start   <= (next_state == FIRE);
            o_pending <= (next_state == ARMED) | next_pend;
        end
    end

`ifdef START_TRIG_CNT_EN
    // Counts entries into FIRE, saturating at 255.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_trig_cnt <= 8'd0;
        end else if (next_state == FIRE && state != FIRE && o_trig_cnt != 8'hFF) begin
            o_trig_cnt <= o_trig_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_start_trigger.sv
// Directed bench for start_trigger: reset, clean press, glitch rejection, busy hold-off,
// single-depth queueing and the WAIT_ACK timeout, all with hand-computed per-edge expectations.
module tb_start_trigger;

    logic i_clk = 1'b0;
    logic i_rst;
    logic i_ce;
    logic i_btn;
    logic i_busy;
    logic o_start;
    logic o_pending;
    logic o_btn_db;
`ifdef START_TRIG_CNT_EN
    logic [7:0] o_trig_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;
    int starts;

    start_trigger #(.DEB_VAL(4), .DEB_VAL_SIZE(3)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_ce      (i_ce),
        .i_btn     (i_btn),
        .i_busy    (i_busy),
        .o_start   (o_start),
        .o_pending (o_pending),
`ifdef START_TRIG_CNT_EN
        .o_trig_cnt(o_trig_cnt),
`endif
        .o_btn_db  (o_btn_db)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic s, input logic p, input logic d);
        check_output({tag, ".start"}, {7'd0, o_start}, {7'd0, s});
        check_output({tag, ".pending"}, {7'd0, o_pending}, {7'd0, p});
        check_output({tag, ".btn_db"}, {7'd0, o_btn_db}, {7'd0, d});
`ifdef START_TRIG_CNT_EN
        check_output({tag, ".trig_cnt"}, o_trig_cnt, 8'(exp_cnt));
`endif
    endtask

    initial begin
        i_rst  = 1'b1;
        i_ce   = 1'b1;
        i_btn  = 1'b0;
        i_busy = 1'b0;
        tick();
        check_all("rst_hold", 1'b0, 1'b0, 1'b0);
        tick();
        i_rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check_all("post_rst", 1'b0, 1'b0, 1'b0);
        end

        // Clean press: db up after edge 6, start pulse after edge 7 only.
        i_btn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 7) exp_cnt++;
            check_all("clean", e == 7, 1'b0, e >= 6);
        end
        i_btn = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            check_all("clean_rel", 1'b0, 1'b0, e < 6);
        end

        // Three-cycle glitch is one enabled sample short.
        i_btn = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check_all("glitch3", 1'b0, 1'b0, 1'b0);
            if (e == 3) i_btn = 1'b0;
        end

        // Twelve-cycle pulse with ce every 4th cycle yields only three enabled samples.
        for (int i = 0; i < 24; i++) begin
            i_btn = (i < 12);
            i_ce  = ((i % 4) == 3);
            tick();
            check_all("glitch_ce", 1'b0, 1'b0, 1'b0);
        end
        i_ce  = 1'b1;
        i_btn = 1'b0;
        repeat (4) tick();

        // Busy hold-off: ARMED after edge 7, fire one edge after busy drops.
        i_busy = 1'b1;
        i_btn  = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check_all("busy_hold", 1'b0, e >= 7, e >= 6);
        end
        i_busy = 1'b0;
        tick();
        exp_cnt++;
        check_all("busy_fire", 1'b1, 1'b0, 1'b1);
        tick();
        check_all("busy_after", 1'b0, 1'b0, 1'b1);
        i_btn = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            check_all("busy_rel", 1'b0, 1'b0, e < 6);
        end

        // Two presses while busy collapse to a single start.
        i_busy = 1'b1;
        i_btn  = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            check_all("queue_hold", 1'b0, e >= 7, (e >= 6 && e < 14) || (e >= 22 && e < 30));
            if (e == 8)  i_btn = 1'b0;
            if (e == 16) i_btn = 1'b1;
            if (e == 24) i_btn = 1'b0;
        end
        i_busy = 1'b0;
        tick();
        exp_cnt++;
        check_all("queue_fire", 1'b1, 1'b0, 1'b0);
        starts = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (o_start) starts++;
        end
        check_output("queue_extra_starts", 8'(starts), 8'd0);
        check_all("queue_end", 1'b0, 1'b0, 1'b0);

        // Rise during FIRE is parked, WAIT_ACK times out after 4 cycles, then refires.
        i_busy = 1'b1;
        i_btn  = 1'b1;
        for (int e = 1; e <= 34; e++) begin
            tick();
            if (e == 22 || e == 28) exp_cnt++;
            check_all("timeout", e == 22 || e == 28,
                      (e >= 7 && e <= 21) || (e >= 23 && e <= 27),
                      (e >= 6 && e < 14) || e >= 22);
            if (e == 8)  i_btn  = 1'b0;
            if (e == 16) i_btn  = 1'b1;
            if (e == 21) i_busy = 1'b0;
        end
        i_btn = 1'b0;
        repeat (12) tick();
        check_all("timeout_end", 1'b0, 1'b0, 1'b0);

        // Reset mid-operation discards the pending request asynchronously.
        i_busy = 1'b1;
        i_btn  = 1'b1;
        repeat (8) tick();
        check_all("pre_rst", 1'b0, 1'b1, 1'b1);
        #2;
        i_rst   = 1'b1;
        exp_cnt = 0;
        #1;
        check_all("rst_async", 1'b0, 1'b0, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            tick();
            check_all("rst_mid", 1'b0, 1'b0, 1'b0);
        end
        i_rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_all("rst_release", 1'b0, e >= 7, e >= 6);
        end
        i_busy = 1'b0;
        i_btn  = 1'b0;
        tick();
        exp_cnt++;
        check_all("rst_refire", 1'b1, 1'b0, 1'b1);
        repeat (16) tick();
        check_all("final", 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
